// File: rtl/seq_mult_core.sv
// Sequential shift-and-add multiplier: one partial product per clock, WIDTH cycles per result.
// Optional two's-complement mode is built only when MULT_SIGNED_EN is defined.
module seq_mult_core #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               sgn,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] p
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_busy_nxt;
    logic              w_done_nxt;
    logic              w_last;
    logic [PW-1:0]     r_acc;
    logic [PW-1:0]     r_mcand;
    logic [WIDTH-1:0]  r_mplier;
    logic [CW-1:0]     r_cnt;
    logic              r_neg;
    logic              r_busy;
    logic              r_done;
    logic [PW-1:0]     r_p;
    logic [PW-1:0]     w_acc_sum;
    logic [PW-1:0]     w_result;
    logic [WIDTH-1:0]  w_mag_a;
    logic [WIDTH-1:0]  w_mag_b;
    logic              w_neg_load;

    assign w_last    = (r_cnt == CW'(1));
    assign w_acc_sum = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

`ifdef MULT_SIGNED_EN
    function automatic logic [WIDTH-1:0] f_mag(input logic [WIDTH-1:0] v);
        if (v[WIDTH-1]) begin
            f_mag = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            f_mag = v;
        end
    endfunction

    function automatic logic [PW-1:0] f_neg(input logic [PW-1:0] v);
        f_neg = ~v + {{(PW-1){1'b0}}, 1'b1};
    endfunction

    // The most negative operand maps to 2^(WIDTH-1), which is still exact as an unsigned magnitude.
    assign w_mag_a    = sgn ? f_mag(a) : a;
    assign w_mag_b    = sgn ? f_mag(b) : b;
    assign w_neg_load = sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
    assign w_result   = r_neg ? f_neg(w_acc_sum) : w_acc_sum;
`else
    logic w_unused_sign;
    assign w_mag_a       = a;
    assign w_mag_b       = b;
    assign w_neg_load    = 1'b0;
    assign w_result      = w_acc_sum;
    assign w_unused_sign = sgn ^ r_neg;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Output decode, registered below so busy/done change on the same edge as the state
    always_comb begin
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_busy_nxt = start;
                w_done_nxt = 1'b0;
            end
            ST_RUN: begin
                w_busy_nxt = ~w_last;
                w_done_nxt = w_last;
            end
            default: begin
                w_busy_nxt = 1'b0;
                w_done_nxt = 1'b0;
            end
        endcase
    end

    // Handshake output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
        end
    end

    // Shift-and-add datapath and held product
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc    <= {PW{1'b0}};
            r_mcand  <= {PW{1'b0}};
            r_mplier <= {WIDTH{1'b0}};
            r_cnt    <= {CW{1'b0}};
            r_neg    <= 1'b0;
            r_p      <= {PW{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_acc    <= {PW{1'b0}};
                        r_mcand  <= {{WIDTH{1'b0}}, w_mag_a};
                        r_mplier <= w_mag_b;
                        r_cnt    <= CW'(WIDTH);
                        r_neg    <= w_neg_load;
                    end
                end
                ST_RUN: begin
                    r_acc    <= w_acc_sum;
                    r_mcand  <= {r_mcand[PW-2:0], 1'b0};
                    r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
                    r_cnt    <= r_cnt - CW'(1);
                    if (w_last) begin
                        r_p <= w_result;
                    end
                end
                default: begin
                    r_acc <= {PW{1'b0}};
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign p    = r_p;

endmodule
